// File: rtl/bw_test_pkg.sv
// Shared types and constants for the AXI-Stream bandwidth tester.
// Contents: TX FSM state enum, 32-bit lane width, default burst length,
// and a saturating increment helper used by the RX error counter.
package bw_test_pkg;
  localparam int          LANE_W      = 32;
  localparam logic [31:0] DEF_BEATS_C = 32'h0200_0000;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/axis_bw_checker.sv
// RX side of the bandwidth tester: accepts every inbound beat, counts beats,
// captures lane 0 of the last beat and, when BW_RX_CHECK_EN is defined,
// compares each 32-bit lane against the expected sequence number.
// Ports:
//   clock, resetn       clock, async active-low reset
//   clr                 clears counters and expected seq (run start)
//   tdata/tvalid        inbound stream; tready is driven by this block
//   rx_beats            accepted beats since last clr (wraps)
//   rx_errors           beats with any lane mismatch (saturating); 0 if check off
//   rcvd_data           lane 0 of the last accepted beat
// Optional feature macro: BW_RX_CHECK_EN.
module axis_bw_checker
  import bw_test_pkg::*;
#(
  parameter int DW = 256
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clr,
  input  logic [DW-1:0] tdata,
  input  logic          tvalid,
  output logic          tready,
  output logic [31:0]   rx_beats,
  output logic [31:0]   rx_errors,
  output logic [31:0]   rcvd_data
);
  localparam int LANES = DW / LANE_W;

  logic hs;
  assign hs = tvalid && tready;

  // tready comes up one cycle after reset release and stays high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tready    <= 1'b0;
      rx_beats  <= '0;
      rcvd_data <= '0;
    end else begin
      tready <= 1'b1;
      if (hs) rcvd_data <= tdata[LANE_W-1:0];
      // A beat coinciding with clr is dropped from the count.
      if (clr)     rx_beats <= '0;
      else if (hs) rx_beats <= rx_beats + 32'd1;
    end
  end

`ifdef BW_RX_CHECK_EN
  logic [31:0] exp_seq;
  logic        mism;

  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (tdata[i*LANE_W +: LANE_W] != exp_seq) mism = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp_seq   <= '0;
      rx_errors <= '0;
    end else if (clr) begin
      exp_seq   <= '0;
      rx_errors <= '0;
    end else if (hs) begin
      if (mism) begin
        rx_errors <= sat_inc(rx_errors);
        // Resync on whatever lane 0 carried so one bad beat costs one error.
        exp_seq   <= tdata[LANE_W-1:0] + 32'd1;
      end else begin
        exp_seq <= exp_seq + 32'd1;
      end
    end
  end
`else
  logic unused_data;
  assign unused_data = ^tdata;
  assign rx_errors   = '0;
`endif
endmodule

// File: rtl/axis_bw_tester.sv
// AXI-Stream bandwidth tester for the C2C link.
// TX: on start, sends N sequence-numbered beats (seq replicated in every
// 32-bit lane), TLAST every PKT_LEN beats and on the final beat, and reports
// cycles from first TVALID to final handshake. RX: see axis_bw_checker.
// Ports:
//   clock, resetn              clock, async active-low reset
//   start, beat_count          run trigger and length (0 -> DEF_BEATS)
//   busy, done, xfer_time      run status, end pulse, measured cycles
//   rx_beats, rx_errors, rcvd_data   RX statistics
//   IN_AXIS_*, OUT_AXIS_*      inbound / outbound streams
// Optional feature macro: BW_RX_CHECK_EN (RX pattern compare).
module axis_bw_tester
  import bw_test_pkg::*;
#(
  parameter int          DW        = 256,
  parameter int          PKT_LEN   = 1,
  parameter logic [31:0] DEF_BEATS = DEF_BEATS_C
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [31:0]   beat_count,
  output logic          busy,
  output logic          done,
  output logic [63:0]   xfer_time,
  output logic [31:0]   rx_beats,
  output logic [31:0]   rx_errors,
  output logic [31:0]   rcvd_data,
  input  logic [DW-1:0] IN_AXIS_TDATA,
  input  logic          IN_AXIS_TVALID,
  input  logic          IN_AXIS_TLAST,
  output logic          IN_AXIS_TREADY,
  output logic [DW-1:0] OUT_AXIS_TDATA,
  output logic          OUT_AXIS_TVALID,
  output logic          OUT_AXIS_TLAST,
  input  logic          OUT_AXIS_TREADY
);
  localparam logic [31:0] PKT_LAST = 32'(PKT_LEN - 1);

  state_e      state;
  logic [63:0] cycle_counter;
  logic [63:0] t0;
  logic [31:0] n_beats;
  logic [31:0] seq;
  logic [31:0] pkt_cnt;
  logic        clr;
  logic        unused_tlast;

  assign unused_tlast = IN_AXIS_TLAST;
  assign clr          = start && (state == IDLE);

  // Data and TLAST derive only from registered seq/pkt_cnt, so they hold
  // steady for as long as a beat is stalled.
  assign OUT_AXIS_TDATA = {(DW/LANE_W){seq}};
  assign OUT_AXIS_TLAST = (pkt_cnt == PKT_LAST) || (seq == n_beats - 32'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cycle_counter <= '0;
    else         cycle_counter <= cycle_counter + 64'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      OUT_AXIS_TVALID <= 1'b0;
      xfer_time       <= '0;
      t0              <= '0;
      n_beats         <= '0;
      seq             <= '0;
      pkt_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_beats         <= (beat_count != 32'd0) ? beat_count : DEF_BEATS;
            seq             <= '0;
            pkt_cnt         <= '0;
            // Counter value seen during the first SEND cycle.
            t0              <= cycle_counter + 64'd1;
            OUT_AXIS_TVALID <= 1'b1;
            busy            <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (OUT_AXIS_TVALID && OUT_AXIS_TREADY) begin
            seq     <= seq + 32'd1;
            pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 32'd1;
            if (seq == n_beats - 32'd1) begin
              xfer_time       <= cycle_counter - t0 + 64'd1;
              OUT_AXIS_TVALID <= 1'b0;
              done            <= 1'b1;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_bw_checker #(.DW(DW)) u_chk (
    .clock     (clock),
    .resetn    (resetn),
    .clr       (clr),
    .tdata     (IN_AXIS_TDATA),
    .tvalid    (IN_AXIS_TVALID),
    .tready    (IN_AXIS_TREADY),
    .rx_beats  (rx_beats),
    .rx_errors (rx_errors),
    .rcvd_data (rcvd_data)
  );
endmodule

// File: tb/tb_axis_bw_tester.sv
module tb_axis_bw_tester;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

`ifdef BW_RX_CHECK_EN
  localparam logic [63:0] CORR_ERR = 64'd1;
`else
  localparam logic [63:0] CORR_ERR = 64'd0;
`endif

  // ---------------- instance A: DW=256, PKT_LEN=1 ----------------
  logic          a_start = 0;
  logic [31:0]   a_cnt = 0;
  logic          a_busy, a_done, a_irdy, a_ov, a_olast;
  logic [63:0]   a_xfer;
  logic [31:0]   a_rxb, a_rxe, a_rcvd;
  logic [255:0]  a_odata, a_idata;
  logic          a_ivalid;
  logic          a_ordy = 1'b1;
  logic          tog_mode = 0, tog_armed = 0;
  logic          lb = 0, corrupt = 0;
  logic          d_valid = 0;
  logic [255:0]  d_data = '0;
  logic [255:0]  corr_mask;

  assign corr_mask = (corrupt && a_odata[31:0] == 32'd50) ? (256'h1 << 96) : '0;
  assign a_idata   = lb ? (a_odata ^ corr_mask) : d_data;
  assign a_ivalid  = lb ? (a_ov && a_ordy) : d_valid;

  axis_bw_tester u_a (
    .clock(clock), .resetn(resetn), .start(a_start), .beat_count(a_cnt),
    .busy(a_busy), .done(a_done), .xfer_time(a_xfer),
    .rx_beats(a_rxb), .rx_errors(a_rxe), .rcvd_data(a_rcvd),
    .IN_AXIS_TDATA(a_idata), .IN_AXIS_TVALID(a_ivalid), .IN_AXIS_TLAST(a_olast),
    .IN_AXIS_TREADY(a_irdy),
    .OUT_AXIS_TDATA(a_odata), .OUT_AXIS_TVALID(a_ov), .OUT_AXIS_TLAST(a_olast),
    .OUT_AXIS_TREADY(a_ordy)
  );

  // ---------------- instance B: DW=64, PKT_LEN=4, DEF_BEATS=8 ----------------
  logic          b_start = 0;
  logic [31:0]   b_cnt = 0;
  logic          b_busy, b_done, b_irdy, b_ov, b_olast;
  logic [63:0]   b_xfer;
  logic [31:0]   b_rxb, b_rxe, b_rcvd;
  logic [63:0]   b_odata;

  axis_bw_tester #(.DW(64), .PKT_LEN(4), .DEF_BEATS(32'd8)) u_b (
    .clock(clock), .resetn(resetn), .start(b_start), .beat_count(b_cnt),
    .busy(b_busy), .done(b_done), .xfer_time(b_xfer),
    .rx_beats(b_rxb), .rx_errors(b_rxe), .rcvd_data(b_rcvd),
    .IN_AXIS_TDATA(64'd0), .IN_AXIS_TVALID(1'b0), .IN_AXIS_TLAST(1'b0),
    .IN_AXIS_TREADY(b_irdy),
    .OUT_AXIS_TDATA(b_odata), .OUT_AXIS_TVALID(b_ov), .OUT_AXIS_TLAST(b_olast),
    .OUT_AXIS_TREADY(1'b1)
  );

  // ---------------- monitors ----------------
  int a_n = 0, a_base = 0, a_seq_bad = 0, a_lane_bad = 0, a_last_bad = 0;
  int a_hold_bad = 0, a_done_cnt = 0;
  logic          a_prev_stall = 0;
  logic [255:0]  a_prev_data = '0;
  int b_n = 0, b_base = 0, b_seq_bad = 0, b_done_cnt = 0;
  logic          b_last_q [0:63];

  always @(posedge clock) begin
    if (a_prev_stall && a_odata != a_prev_data) a_hold_bad++;
    a_prev_stall = a_ov && !a_ordy;
    a_prev_data  = a_odata;
    if (a_done) a_done_cnt++;
    if (a_ov && a_ordy) begin
      if (a_odata[31:0] != 32'(a_n - a_base)) a_seq_bad++;
      if (a_odata != {8{a_odata[31:0]}}) a_lane_bad++;
      if (!a_olast) a_last_bad++;
      a_n++;
    end
    if (b_done) b_done_cnt++;
    if (b_ov) begin
      if (b_odata != {2{32'(b_n - b_base)}}) b_seq_bad++;
      b_last_q[(b_n - b_base) & 63] = b_olast;
      b_n++;
    end
  end

  // TREADY 1,0,1,0... starting with 1 on the first TVALID cycle.
  always @(negedge clock) begin
    if (tog_mode && a_ov) begin
      if (!tog_armed) tog_armed = 1'b1;
      else            a_ordy = ~a_ordy;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_a(input logic [31:0] cnt);
    a_base = a_n;
    a_cnt = cnt; a_start = 1;
    @(negedge clock); a_start = 0;
  endtask

  task automatic wait_a_idle();
    logic ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (!a_busy) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_a", 1, 0);
  endtask

  task automatic wait_b_idle();
    logic ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!b_busy) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_b", 1, 0);
  endtask

  function automatic logic [63:0] b_mask(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = b_last_q[i];
    return m;
  endfunction

  int d0;

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clock);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_tvalid", a_ov, 0);
    chk("rst_in_tready", a_irdy, 0);
    chk("rst_xfer", a_xfer, 0);
    chk("rst_rx_beats", a_rxb, 0);
    chk("rst_rx_err", a_rxe, 0);
    resetn = 1;
    @(negedge clock);
    chk("in_tready_up", a_irdy, 1);

    // ---- 1: 16 beats, TREADY=1 ----
    d0 = a_done_cnt;
    pulse_a(16);
    wait_a_idle();
    chk("t1_beats", a_n - a_base, 16);
    chk("t1_seq_bad", a_seq_bad, 0);
    chk("t1_lane_bad", a_lane_bad, 0);
    chk("t1_tlast_every", a_last_bad, 0);
    chk("t1_done_pulses", a_done_cnt - d0, 1);
    chk("t1_xfer", a_xfer, 16);

    // ---- 2: TREADY toggling ----
    tog_mode = 1; tog_armed = 0; a_ordy = 1;
    d0 = a_done_cnt;
    pulse_a(16);
    wait_a_idle();
    tog_mode = 0; a_ordy = 1;
    chk("t2_beats", a_n - a_base, 16);
    chk("t2_seq_bad", a_seq_bad, 0);
    chk("t2_hold_bad", a_hold_bad, 0);
    chk("t2_xfer", a_xfer, 31);
    chk("t2_done_pulses", a_done_cnt - d0, 1);

    // ---- 4: loopback, clean then corrupted beat 50 ----
    lb = 1;
    pulse_a(100);
    wait_a_idle();
    @(negedge clock);
    chk("t4_rx_beats", a_rxb, 100);
    chk("t4_rx_err", a_rxe, 0);
    chk("t4_rcvd", a_rcvd, 99);
    corrupt = 1;
    pulse_a(100);
    wait_a_idle();
    @(negedge clock);
    chk("t4c_rx_beats", a_rxb, 100);
    chk("t4c_rx_err", a_rxe, CORR_ERR);
    corrupt = 0; lb = 0;

    // ---- start coinciding with an RX beat ----
    d_valid = 1; d_data = {8{32'd100}};
    repeat (3) @(negedge clock);
    chk("rx_direct_cnt", a_rxb, 103);
    chk("rx_direct_data", a_rcvd, 100);
    a_cnt = 1; a_start = 1; a_base = a_n;
    @(negedge clock);
    a_start = 0; d_valid = 0;
    chk("rx_clr_same_beat", a_rxb, 0);
    wait_a_idle();

    // ---- 5: reset mid-run ----
    d0 = a_done_cnt;
    pulse_a(16);
    for (int i = 0; i < 100; i++) begin
      if (a_n - a_base >= 5) break;
      @(negedge clock);
    end
    chk("t5_beats_before_rst", a_n - a_base, 5);
    resetn = 0;
    #1;
    chk("t5_tvalid", a_ov, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_xfer", a_xfer, 0);
    repeat (3) @(negedge clock);
    chk("t5_no_done", a_done_cnt - d0, 0);
    resetn = 1;
    @(negedge clock);
    d0 = a_seq_bad;
    pulse_a(16);
    wait_a_idle();
    chk("t5_rerun_beats", a_n - a_base, 16);
    chk("t5_rerun_seq", a_seq_bad - d0, 0);
    chk("t5_rerun_xfer", a_xfer, 16);

    // ---- 3: PKT_LEN=4, 10 beats ----
    b_base = b_n; b_cnt = 10; b_start = 1;
    @(negedge clock); b_start = 0;
    wait_b_idle();
    chk("t3_beats", b_n - b_base, 10);
    chk("t3_tlast_mask", b_mask(10), 64'h288);
    chk("t3_seq_bad", b_seq_bad, 0);

    // ---- 6: beat_count=0 -> DEF_BEATS=8; start during SEND ignored ----
    d0 = b_done_cnt;
    b_base = b_n; b_cnt = 0; b_start = 1;
    @(negedge clock); b_start = 0;
    repeat (2) @(negedge clock);
    b_cnt = 3; b_start = 1;
    @(negedge clock); b_start = 0;
    wait_b_idle();
    repeat (4) @(negedge clock);
    chk("t6_beats", b_n - b_base, 8);
    chk("t6_tlast_mask", b_mask(8), 64'h88);
    chk("t6_done_pulses", b_done_cnt - d0, 1);
    chk("t6_still_idle", b_busy, 0);
    chk("t6_xfer", b_xfer, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
